// File: rtl/cpu_reg_package.sv
// Shared CPU-bus constants and register layouts for the bus FIFO responder.
// Provides the bus widths, the register offsets inside the 16-byte window
// and the packed bit layout of the STATUS register.
package cpu_reg_package;

    localparam int address_width = 32;
    localparam int data_width    = 32;

    // Word offsets (bus_addr_i[3:2]) of the four responder registers.
    localparam logic [1:0] FIFO_DATA_OFS   = 2'd0;
    localparam logic [1:0] FIFO_STATUS_OFS = 2'd1;
    localparam logic [1:0] FIFO_IRQEN_OFS  = 2'd2;
    localparam logic [1:0] FIFO_CTRL_OFS   = 2'd3;

    // STATUS register layout, MSB first.
    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] rx_count;
        logic [7:0] tx_count;
        logic [1:0] rsvd_lo;
        logic       rx_underflow;
        logic       tx_overflow;
        logic       rx_full;
        logic       rx_empty;
        logic       tx_full;
        logic       tx_empty;
    } fifo_status_t;

    // Even parity over a bus word, available for integrity checks on stored data.
    function automatic logic word_parity(input logic [data_width-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bus_fifo_responder_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers carrying one extra bit so that
// full and empty are distinguishable. A push while full is accepted when a
// pop frees the slot in the same cycle; flush wins over push and pop.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push_s;
    logic             do_pop_s;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign data_o    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Next-state pointers: flush empties the FIFO, otherwise advance on accepted ops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = {(AW+1){1'b0}};
            rd_ptr_d = {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are unreachable once pointers reset, so no clear needed.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !flush_i && !reset_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/bus_fifo_responder.sv
// CPU bus responder with a TX FIFO (CPU writes -> external stream) and an RX
// FIFO (external stream -> CPU reads), STATUS/IRQ_EN/CTRL registers in a
// 16-byte window at BASE_ADDR.
// Optional feature macro: BUS_FIFO_IRQ_EN (IRQ_EN register and irq_o).
// Without it IRQ_EN reads 0, ignores writes, and irq_o is tied low.
module bus_fifo_responder
    import cpu_reg_package::*;
#(
    parameter logic [address_width-1:0] BASE_ADDR  = 32'h0000_9000,
    parameter int                       FIFO_DEPTH = 16,
    parameter int                       DATA_W     = data_width
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] bus_addr_i,
    input  logic                     bus_we_i,
    input  logic                     bus_re_i,
    input  logic [DATA_W-1:0]        bus_wdata_i,
    output logic [DATA_W-1:0]        bus_rdata_o,
    output logic                     irq_o,
    output logic [DATA_W-1:0]        tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    input  logic [DATA_W-1:0]        rx_data_i,
    input  logic                     rx_valid_i,
    output logic                     rx_ready_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Bus decode.
    logic              hit_s;
    logic [1:0]        ofs_s;
    logic              wr_hit_s;
    logic              rd_s;
    logic              rd_hit_s;
    logic              ctrl_wr_s;

    // FIFO interface.
    logic              tx_push_s;
    logic              tx_pop_s;
    logic              tx_flush_s;
    logic              tx_full_s;
    logic              tx_empty_s;
    logic [CNT_W-1:0]  tx_count_s;
    logic [DATA_W-1:0] tx_head_s;
    logic              rx_push_s;
    logic              rx_pop_s;
    logic              rx_flush_s;
    logic              rx_full_s;
    logic              rx_empty_s;
    logic [CNT_W-1:0]  rx_count_s;
    logic [DATA_W-1:0] rx_head_s;

    // Sticky flags.
    logic              tx_overflow_q;
    logic              tx_overflow_d;
    logic              rx_underflow_q;
    logic              rx_underflow_d;
    logic              sticky_clr_s;
    logic              ovf_set_s;
    logic              unf_set_s;

    // Read path.
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    fifo_status_t      status_s;
    logic [1:0]        irq_en_s;
    logic              unused_s;

    assign hit_s     = (bus_addr_i[address_width-1:4] == BASE_ADDR[address_width-1:4]);
    assign ofs_s     = bus_addr_i[3:2];
    assign wr_hit_s  = bus_we_i & hit_s;
    // A simultaneous write strobe suppresses the read entirely.
    assign rd_s      = bus_re_i & ~bus_we_i;
    assign rd_hit_s  = rd_s & hit_s;
    assign ctrl_wr_s = wr_hit_s & (ofs_s == FIFO_CTRL_OFS);

    assign tx_push_s    = wr_hit_s & (ofs_s == FIFO_DATA_OFS);
    assign tx_pop_s     = tx_valid_o & tx_ready_i;
    assign tx_flush_s   = ctrl_wr_s & bus_wdata_i[0];
    assign rx_flush_s   = ctrl_wr_s & bus_wdata_i[1];
    assign sticky_clr_s = ctrl_wr_s & bus_wdata_i[2];

    assign rx_pop_s  = rd_hit_s & (ofs_s == FIFO_DATA_OFS) & ~rx_empty_s;
    assign rx_push_s = rx_valid_i & rx_ready_o;

    // A full TX FIFO still accepts a write when the stream drains a word the same cycle.
    assign ovf_set_s = tx_push_s & tx_full_s & ~tx_pop_s;
    assign unf_set_s = rd_hit_s & (ofs_s == FIFO_DATA_OFS) & rx_empty_s;

    // The RX side is ready when a slot is free now or is being freed by a CPU pop.
    assign rx_ready_o = ~reset_i & (~rx_full_s | rx_pop_s);
    assign tx_valid_o = ~tx_empty_s;
    assign tx_data_o  = tx_empty_s ? {DATA_W{1'b0}} : tx_head_s;
    assign bus_rdata_o = rdata_q;

    assign unused_s = ^{bus_addr_i[1:0], bus_wdata_i};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (tx_push_s),
        .pop_i   (tx_pop_s),
        .flush_i (tx_flush_s),
        .data_i  (bus_wdata_i),
        .data_o  (tx_head_s),
        .full_o  (tx_full_s),
        .empty_o (tx_empty_s),
        .count_o (tx_count_s)
    );

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (rx_push_s),
        .pop_i   (rx_pop_s),
        .flush_i (rx_flush_s),
        .data_i  (rx_data_i),
        .data_o  (rx_head_s),
        .full_o  (rx_full_s),
        .empty_o (rx_empty_s),
        .count_o (rx_count_s)
    );

`ifdef BUS_FIFO_IRQ_EN
    logic [1:0] irq_en_q;
    logic [1:0] irq_en_d;
    logic       irq_q;
    logic       irq_d;

    // IRQ_EN next state and interrupt level computed from current FIFO state.
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_hit_s && (ofs_s == FIFO_IRQEN_OFS)) begin
            irq_en_d = bus_wdata_i[1:0];
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_d = (irq_en_q[0] & ~rx_empty_s) | (irq_en_q[1] & tx_empty_s);
    end

    // IRQ_EN and interrupt registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_en_q <= 2'b00;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_s = irq_en_q;
    assign irq_o    = irq_q;
`else
    assign irq_en_s = 2'b00;
    assign irq_o    = 1'b0;
`endif

    // Assemble the STATUS view from FIFO state and sticky flags.
    always_comb begin
        status_s              = '0;
        status_s.rx_count     = 8'(rx_count_s);
        status_s.tx_count     = 8'(tx_count_s);
        status_s.rx_underflow = rx_underflow_q;
        status_s.tx_overflow  = tx_overflow_q;
        status_s.rx_full      = rx_full_s;
        status_s.rx_empty     = rx_empty_s;
        status_s.tx_full      = tx_full_s;
        status_s.tx_empty     = tx_empty_s;
    end

    // Sticky error flags: clear command wins, otherwise accumulate new events.
    always_comb begin
        tx_overflow_d  = tx_overflow_q;
        rx_underflow_d = rx_underflow_q;
        if (sticky_clr_s) begin
            tx_overflow_d  = 1'b0;
            rx_underflow_d = 1'b0;
        end else begin
            tx_overflow_d  = tx_overflow_q | ovf_set_s;
            rx_underflow_d = rx_underflow_q | unf_set_s;
        end
    end

    // Read data mux; value holds between reads, out-of-window reads return zero.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_s) begin
            if (hit_s) begin
                case (ofs_s)
                    FIFO_DATA_OFS:   rdata_d = rx_empty_s ? {DATA_W{1'b0}} : rx_head_s;
                    FIFO_STATUS_OFS: rdata_d = DATA_W'(status_s);
                    FIFO_IRQEN_OFS:  rdata_d = DATA_W'(irq_en_s);
                    FIFO_CTRL_OFS:   rdata_d = {DATA_W{1'b0}};
                    default:         rdata_d = {DATA_W{1'b0}};
                endcase
            end else begin
                rdata_d = {DATA_W{1'b0}};
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data and sticky flag registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q        <= {DATA_W{1'b0}};
            tx_overflow_q  <= 1'b0;
            rx_underflow_q <= 1'b0;
        end else begin
            rdata_q        <= rdata_d;
            tx_overflow_q  <= tx_overflow_d;
            rx_underflow_q <= rx_underflow_d;
        end
    end

endmodule
